// File: rtl/lcd_char_fifo_pkg.sv
//------------------------------------------------------------------------------
// Module   : lcd_char_fifo_pkg
// Brief    : Shared character width, FIFO depth and handshake state encodings.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package lcd_char_fifo_pkg;

   localparam int LCD_DATA_W     = 8;
   localparam int LCD_FIFO_DEPTH = 16;

   typedef enum logic [0:0] {
      IN_IDLE = 1'b0,
      IN_WAIT = 1'b1
   } in_state_t;

   typedef enum logic [0:0] {
      OUT_IDLE = 1'b0,
      OUT_WAIT = 1'b1
   } out_state_t;

endpackage

`default_nettype wire

// File: rtl/lcd_char_fifo_sync_fifo.sv
//------------------------------------------------------------------------------
// Module   : lcd_char_fifo_sync_fifo
// Brief    : Register-array FIFO with wrapping pointers, level counter and flush.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module lcd_char_fifo_sync_fifo
   import lcd_char_fifo_pkg::*;
#(
   parameter  int DATA_W = LCD_DATA_W,
   parameter  int DEPTH  = LCD_FIFO_DEPTH,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_pop,
   input  logic              i_clear,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_full,
   output logic              o_empty,
   output logic [ADDR_W:0]   o_level
);

   localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wptr;
   logic [ADDR_W-1:0] r_rptr;
   logic [ADDR_W:0]   r_level;
   logic              w_do_push;
   logic              w_do_pop;

   assign o_full    = (r_level == C_DEPTH);
   assign o_empty   = (r_level == '0);
   // A flush in the same cycle discards any push or pop.
   assign w_do_push = i_push && !o_full  && !i_clear;
   assign w_do_pop  = i_pop  && !o_empty && !i_clear;
   assign o_rdata   = r_mem[r_rptr];
   assign o_level   = r_level;

   always_ff @(posedge clock) begin
      if (w_do_push) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else if (i_clear) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_do_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/lcd_char_fifo.sv
//------------------------------------------------------------------------------
// Module   : lcd_char_fifo
// Brief    : Buffers processor characters and drains them to the lcd driver.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module lcd_char_fifo
   import lcd_char_fifo_pkg::*;
#(
   parameter  int DATA_W = LCD_DATA_W,
   parameter  int DEPTH  = LCD_FIFO_DEPTH,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] ascii,
   input  logic              consume,
   output logic              ready,
   input  logic              clear,
   output logic [DATA_W-1:0] lcd_ascii,
   output logic              lcd_consume,
   input  logic              lcd_ready,
   output logic [ADDR_W:0]   level
);

   in_state_t         r_in_state;
   out_state_t        r_out_state;
   logic [DATA_W-1:0] r_lcd_ascii;
   logic              r_lcd_consume;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic [DATA_W-1:0] w_rdata;

   assign ready       = (r_in_state == IN_IDLE) && !w_full;
   assign w_push      = consume && ready;
   // No new transfer starts on a flush cycle so the flushed head is never sent.
   assign w_pop       = (r_out_state == OUT_IDLE) && !w_empty && lcd_ready && !clear;
   assign lcd_ascii   = r_lcd_ascii;
   assign lcd_consume = r_lcd_consume;

   lcd_char_fifo_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (w_push),
      .i_wdata (ascii),
      .i_pop   (w_pop),
      .i_clear (clear),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (level)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_in_state <= IN_IDLE;
      end else begin
         case (r_in_state)
            IN_IDLE: if (w_push)   r_in_state <= IN_WAIT;
            IN_WAIT: if (!consume) r_in_state <= IN_IDLE;
            default:               r_in_state <= IN_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_out_state   <= OUT_IDLE;
         r_lcd_ascii   <= '0;
         r_lcd_consume <= 1'b0;
      end else begin
         case (r_out_state)
            OUT_IDLE: begin
               if (w_pop) begin
                  r_lcd_ascii   <= w_rdata;
                  r_lcd_consume <= 1'b1;
                  r_out_state   <= OUT_WAIT;
               end
            end
            OUT_WAIT: begin
               if (!lcd_ready) begin
                  r_lcd_consume <= 1'b0;
                  r_out_state   <= OUT_IDLE;
               end
            end
            default: begin
               r_lcd_consume <= 1'b0;
               r_out_state   <= OUT_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
